// File: rtl/wb_arbiter_pkg.sv
// Shared widths, source indices and helpers for the register-file write-back arbiter.
// Source index order doubles as the fixed tie-break priority.
package wb_arbiter_pkg;

  localparam int unsigned RegBusW  = 32;
  localparam int unsigned RegAddrW = 5;

  typedef logic [RegBusW-1:0]  reg_bus_t;
  typedef logic [RegAddrW-1:0] reg_addr_t;
  typedef logic [3:0]          wait_cnt_t;

  localparam logic WriteEnable = 1'b1;
  localparam logic RstEnable   = 1'b1;

  localparam int unsigned SrcMem = 0;
  localparam int unsigned SrcEx  = 1;
  localparam int unsigned SrcDiv = 2;
  localparam int unsigned SrcNum = 3;

  // Lowest set bit wins, i.e. MEM > EX > DIV.
  function automatic logic [SrcNum-1:0] pick_first(input logic [SrcNum-1:0] req);
    return req & (~req + {{(SrcNum-1){1'b0}}, 1'b1});
  endfunction

endpackage

// File: rtl/wb_slot.sv
// One-entry holding buffer for a write-back source, with a saturating starvation counter.
module wb_slot
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic      clk_i,
  input  logic      rst_i,
  input  logic      load_i,
  input  logic      grant_i,
  input  reg_addr_t waddr_i,
  input  reg_bus_t  wdata_i,
  output logic      occ_o,
  output logic      urgent_o,
  output reg_addr_t waddr_o,
  output reg_bus_t  wdata_o
);

  localparam wait_cnt_t Limit = wait_cnt_t'(STARVE_LIMIT);

  logic      occ_q, occ_d;
  reg_addr_t waddr_q, waddr_d;
  reg_bus_t  wdata_q, wdata_d;
  wait_cnt_t cnt_q, cnt_d;

  // A refill on the grant edge wins over the free and starts a fresh wait.
  always_comb begin
    occ_d   = occ_q;
    waddr_d = waddr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    if (load_i) begin
      occ_d   = 1'b1;
      waddr_d = waddr_i;
      wdata_d = wdata_i;
      cnt_d   = '0;
    end else if (grant_i || !occ_q) begin
      occ_d = 1'b0;
      cnt_d = '0;
    end else if (cnt_q != Limit) begin
      cnt_d = cnt_q + wait_cnt_t'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i == RstEnable) begin
      occ_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      occ_q   <= occ_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  assign occ_o    = occ_q;
  assign urgent_o = occ_q && (cnt_q == Limit);
  assign waddr_o  = waddr_q;
  assign wdata_o  = wdata_q;

endmodule

// File: rtl/wb_arbiter.sv
// Arbitrates MEM/EX/DIV writes onto the single register-file write port, with WAW
// ordering holds and pending-write queries for decode stalls.
module wb_arbiter
  import wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned SRC_NUM      = SrcNum
) (
  input  logic      clk,
  input  logic      rst,
  input  logic      mem_valid,
  input  reg_addr_t mem_waddr,
  input  reg_bus_t  mem_wdata,
  output logic      mem_ready,
  input  logic      ex_valid,
  input  reg_addr_t ex_waddr,
  input  reg_bus_t  ex_wdata,
  output logic      ex_ready,
  input  logic      div_valid,
  input  reg_addr_t div_waddr,
  input  reg_bus_t  div_wdata,
  output logic      div_ready,
  output logic      wb_we,
  output reg_addr_t wb_waddr,
  output reg_bus_t  wb_wdata,
  input  reg_addr_t q_addr_1,
  input  reg_addr_t q_addr_2,
  output logic      q_hit_1,
  output logic      q_hit_2
);

  logic [SRC_NUM-1:0] src_valid, ready, xfer, load, hold;
  logic [SRC_NUM-1:0] occ, urgent, urgent_occ, grant;
  reg_addr_t          src_waddr  [SRC_NUM];
  reg_bus_t           src_wdata  [SRC_NUM];
  reg_addr_t          slot_waddr [SRC_NUM];
  reg_bus_t           slot_wdata [SRC_NUM];

  logic      we_q, we_d;
  reg_addr_t waddr_q, waddr_d, gnt_waddr;
  reg_bus_t  wdata_q, wdata_d, gnt_wdata;

  assign src_valid         = {div_valid, ex_valid, mem_valid};
  assign src_waddr[SrcMem] = mem_waddr;
  assign src_waddr[SrcEx]  = ex_waddr;
  assign src_waddr[SrcDiv] = div_waddr;
  assign src_wdata[SrcMem] = mem_wdata;
  assign src_wdata[SrcEx]  = ex_wdata;
  assign src_wdata[SrcDiv] = div_wdata;

  for (genvar i = 0; i < SRC_NUM; i++) begin : g_slot
    wb_slot #(
      .STARVE_LIMIT(STARVE_LIMIT)
    ) u_slot (
      .clk_i    (clk),
      .rst_i    (rst),
      .load_i   (load[i]),
      .grant_i  (grant[i]),
      .waddr_i  (src_waddr[i]),
      .wdata_i  (src_wdata[i]),
      .occ_o    (occ[i]),
      .urgent_o (urgent[i]),
      .waddr_o  (slot_waddr[i]),
      .wdata_o  (slot_wdata[i])
    );
  end

  assign urgent_occ = occ & urgent;
  assign grant      = (|urgent_occ) ? pick_first(urgent_occ) : pick_first(occ);

  // Sources are resolved in priority order so a lower source sees higher transfers.
  always_comb begin
    ready = '0;
    xfer  = '0;
    load  = '0;
    hold  = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (src_waddr[i] != '0) begin
        for (int j = 0; j < SRC_NUM; j++) begin
          if (j != i && occ[j] && !grant[j] && slot_waddr[j] == src_waddr[i]) hold[i] = 1'b1;
          if (j < i && xfer[j] && src_waddr[j] == src_waddr[i]) hold[i] = 1'b1;
        end
      end
      ready[i] = (rst != RstEnable) && (!occ[i] || grant[i]) && !hold[i];
      xfer[i]  = src_valid[i] && ready[i];
      load[i]  = xfer[i] && (src_waddr[i] != '0);
    end
  end

  assign mem_ready = ready[SrcMem];
  assign ex_ready  = ready[SrcEx];
  assign div_ready = ready[SrcDiv];

  always_comb begin
    q_hit_1 = we_q && (waddr_q == q_addr_1);
    q_hit_2 = we_q && (waddr_q == q_addr_2);
    for (int i = 0; i < SRC_NUM; i++) begin
      if (occ[i] && slot_waddr[i] == q_addr_1) q_hit_1 = 1'b1;
      if (occ[i] && slot_waddr[i] == q_addr_2) q_hit_2 = 1'b1;
    end
    if (q_addr_1 == '0) q_hit_1 = 1'b0;
    if (q_addr_2 == '0) q_hit_2 = 1'b0;
  end

  always_comb begin
    gnt_waddr = '0;
    gnt_wdata = '0;
    for (int i = 0; i < SRC_NUM; i++) begin
      if (grant[i]) begin
        gnt_waddr = slot_waddr[i];
        gnt_wdata = slot_wdata[i];
      end
    end
    we_d    = (|grant) ? WriteEnable : ~WriteEnable;
    waddr_d = (|grant) ? gnt_waddr : waddr_q;
    wdata_d = (|grant) ? gnt_wdata : wdata_q;
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      we_q    <= we_d;
      waddr_q <= waddr_d;
      wdata_q <= wdata_d;
    end
  end

  assign wb_we    = we_q;
  assign wb_waddr = waddr_q;
  assign wb_wdata = wdata_q;

endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: a queue-based reference model predicts grants,
// readies and query hits; a separate monitor pops expected writes off wb_we.
module tb_wb_arbiter;

  localparam int LIMIT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        v  [3];
  logic [4:0]  a  [3];
  logic [31:0] d  [3];
  logic [4:0]  q1, q2;
  logic        mem_ready, ex_ready, div_ready, wb_we, q_hit_1, q_hit_2;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;

  typedef struct {
    int          cyc;
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  wr_t sb[$];
  int  cyc = 0;
  int  n_cmp = 0;
  int  n_err = 0;

  // Reference model state: buffers with an unbounded age since acceptance.
  bit          m_occ [3];
  logic [4:0]  m_ab  [3];
  logic [31:0] m_db  [3];
  int          m_age [3];
  bit          m_we;
  logic [4:0]  m_wa;
  logic [31:0] m_wd;

  wb_arbiter #(
    .STARVE_LIMIT(LIMIT),
    .SRC_NUM     (3)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .mem_valid (v[0]),
    .mem_waddr (a[0]),
    .mem_wdata (d[0]),
    .mem_ready (mem_ready),
    .ex_valid  (v[1]),
    .ex_waddr  (a[1]),
    .ex_wdata  (d[1]),
    .ex_ready  (ex_ready),
    .div_valid (v[2]),
    .div_waddr (a[2]),
    .div_wdata (d[2]),
    .div_ready (div_ready),
    .wb_we     (wb_we),
    .wb_waddr  (wb_waddr),
    .wb_wdata  (wb_wdata),
    .q_addr_1  (q1),
    .q_addr_2  (q2),
    .q_hit_1   (q_hit_1),
    .q_hit_2   (q_hit_2)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference model: evaluated mid-cycle on settled inputs, then advanced to the next cycle.
  initial begin
    int   g;
    bit   rdy [3];
    bit   hit [2];
    logic dr  [3];
    logic [4:0] qa;
    for (int i = 0; i < 3; i++) begin
      m_occ[i] = 0; m_ab[i] = '0; m_db[i] = '0; m_age[i] = 0;
    end
    m_we = 0; m_wa = '0; m_wd = '0;
    forever begin
      @(negedge clk);
      chk("outreg", {58'd0, wb_we, wb_waddr, wb_wdata}, {58'd0, m_we, m_wa, m_wd});
      for (int k = 0; k < 2; k++) begin
        qa = (k == 0) ? q1 : q2;
        hit[k] = 0;
        if (qa != 0) begin
          for (int i = 0; i < 3; i++) if (m_occ[i] && m_ab[i] == qa) hit[k] = 1;
          if (m_we && m_wa == qa) hit[k] = 1;
        end
      end
      g = -1;
      for (int i = 0; i < 3; i++) rdy[i] = 0;
      if (!rst) begin
        for (int i = 0; i < 3; i++) if (g < 0 && m_occ[i] && m_age[i] >= LIMIT) g = i;
        for (int i = 0; i < 3; i++) if (g < 0 && m_occ[i]) g = i;
        for (int i = 0; i < 3; i++) begin
          rdy[i] = !m_occ[i] || g == i;
          if (a[i] != 0) begin
            for (int j = 0; j < 3; j++) begin
              if (j != i && j != g && m_occ[j] && m_ab[j] == a[i]) rdy[i] = 0;
              if (j < i && v[j] && rdy[j] && a[j] == a[i]) rdy[i] = 0;
            end
          end
        end
      end
      dr = '{mem_ready, ex_ready, div_ready};
      chk("mem_ready", {95'd0, dr[0]}, {95'd0, rdy[0]});
      chk("ex_ready",  {95'd0, dr[1]}, {95'd0, rdy[1]});
      chk("div_ready", {95'd0, dr[2]}, {95'd0, rdy[2]});
      chk("q_hit_1",   {95'd0, q_hit_1}, {95'd0, hit[0]});
      chk("q_hit_2",   {95'd0, q_hit_2}, {95'd0, hit[1]});
      if (rst) begin
        for (int i = 0; i < 3; i++) begin
          m_occ[i] = 0; m_ab[i] = '0; m_db[i] = '0; m_age[i] = 0;
        end
        m_we = 0; m_wa = '0; m_wd = '0;
      end else begin
        if (g >= 0) begin
          sb.push_back('{cyc: cyc + 1, a: m_ab[g], d: m_db[g]});
          m_we = 1; m_wa = m_ab[g]; m_wd = m_db[g];
          m_occ[g] = 0;
        end else begin
          m_we = 0;
        end
        for (int i = 0; i < 3; i++) if (m_occ[i]) m_age[i]++;
        for (int i = 0; i < 3; i++) begin
          if (v[i] && rdy[i] && a[i] != 0) begin
            m_occ[i] = 1; m_ab[i] = a[i]; m_db[i] = d[i]; m_age[i] = 0;
          end
        end
      end
    end
  end

  // Monitor: every register-file write must match the oldest expected write, on time.
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (wb_we) begin
        if (sb.size() == 0) begin
          n_cmp++; n_err++;
          $display("FAIL spurious_write: got addr %0d data %0h expected no write (cycle %0d)",
                   wb_waddr, wb_wdata, cyc);
        end else begin
          e = sb.pop_front();
          chk("write", {32'(cyc), 27'd0, wb_waddr, wb_wdata}, {32'(e.cyc), 27'd0, e.a, e.d});
        end
      end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
        e = sb.pop_front();
        n_cmp++; n_err++;
        $display("FAIL missing_write: got none expected addr %0d data %0h (cycle %0d)",
                 e.a, e.d, cyc);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [2:0] vm, input logic [4:0] a0, input logic [4:0] a1,
                       input logic [4:0] a2, input logic [31:0] d0, input logic [31:0] d1,
                       input logic [31:0] d2, input int n);
    v[0] = vm[0]; v[1] = vm[1]; v[2] = vm[2];
    a[0] = a0; a[1] = a1; a[2] = a2;
    d[0] = d0; d[1] = d1; d[2] = d2;
    repeat (n) tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      v[i] = 1'b0; a[i] = '0; d[i] = '0;
    end
    q1 = '0; q2 = '0;
    repeat (2) tick();
    rst = 1'b0;

    // Single EX write to r5, queried while buffered and while on the port.
    q1 = 5'd5; q2 = 5'd6;
    drive(3'b010, 0, 5, 0, 0, 32'h1234, 0, 1);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 3);

    // Three-way collision.
    q1 = 5'd2; q2 = 5'd3;
    drive(3'b111, 1, 2, 3, 32'hA, 32'hB, 32'hC, 1);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 4);

    // Starvation: EX accepted a cycle ahead of DIV, MEM and EX stream every cycle.
    q1 = 5'd7;
    drive(3'b011, 10, 20, 0, 32'h100, 32'h200, 0, 1);
    drive(3'b111, 11, 21, 7, 32'h101, 32'h201, 32'h777, 1);
    for (int k = 0; k < 10; k++)
      drive(3'b011, 5'(12 + k % 4), 5'(22 + k % 4), 0, 32'(k + 'h110), 32'(k + 'h210), 0, 1);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 8);

    // Register zero is accepted and dropped.
    q1 = 5'd0; q2 = 5'd0;
    drive(3'b001, 0, 0, 0, 32'hFFFF, 0, 0, 1);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 3);

    // WAW hold: EX r9 must wait behind DIV r9 while MEM keeps winning.
    q1 = 5'd9; q2 = 5'd11;
    drive(3'b101, 11, 0, 9, 32'h11, 0, 32'h999, 1);
    for (int k = 0; k < 8; k++)
      drive(3'b011, 5'(12 + k % 3), 9, 0, 32'(k + 'h20), 32'(k + 'h900), 0, 1);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 6);

    // Reset mid-flight discards all three buffers and the pending grant.
    q1 = 5'd1; q2 = 5'd3;
    drive(3'b111, 1, 2, 3, 32'h1, 32'h2, 32'h3, 1);
    rst = 1'b1;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 1);
    rst = 1'b0;
    drive(3'b111, 4, 5, 6, 32'h4, 32'h5, 32'h6, 1);
    drive(3'b000, 0, 0, 0, 0, 0, 0, 5);

    // Randomized traffic on a small address set to provoke holds and collisions.
    for (int n = 0; n < 1500; n++) begin
      for (int i = 0; i < 3; i++) begin
        v[i] = ($urandom_range(0, 9) < 6);
        a[i] = 5'($urandom_range(0, 4));
        d[i] = $urandom;
      end
      q1  = 5'($urandom_range(0, 5));
      q2  = 5'($urandom_range(0, 5));
      rst = ($urandom_range(0, 99) == 0);
      tick();
    end
    rst = 1'b0;
    drive(3'b000, 0, 0, 0, 0, 0, 0, 10);

    chk("drain", 96'(sb.size()), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
